// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory read bus (req/ack with wait states)
interface instr_fetch_if #(
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder issuing instruction-memory reads and strobing fetched words into the IR
module instr_fetch #(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [15:0]   HALT_WORD = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 fetch_start,
    input  logic                 jump_en,
    input  logic [AW-1:0]        jump_addr,
    instr_fetch_if.master        mem,
    output logic [15:0]          IM,
    output logic                 ir_wr,
    output logic [AW-1:0]        pc,
    output logic                 fetch_done,
    output logic                 busy,
    output logic                 halted
);
    typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc_q, addr_q, tgt_q;
    logic [15:0]   buf_q;
    logic          pend_q, halted_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: start only when not halted, wait as long as memory needs, LOAD lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (fetch_start && !halted_q) ? REQ : IDLE;
            REQ:     state_nxt = mem.imem_ack ? LOAD : REQ;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem.imem_req  = (state == REQ);
    assign mem.imem_addr = addr_q;
    assign ir_wr         = (state == LOAD);
    assign fetch_done    = (state == LOAD);
    assign busy          = (state != IDLE);
    assign IM            = buf_q;
    assign pc            = pc_q;
    assign halted        = halted_q;

    // Datapath: PC, request address, data buffer, pending jump and halt flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            tgt_q    <= '0;
            pend_q   <= 1'b0;
            buf_q    <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_en) begin
                        pc_q     <= jump_addr;
                        halted_q <= 1'b0;
                    end
                    if (fetch_start && !halted_q) addr_q <= jump_en ? jump_addr : pc_q;
                end
                REQ: begin
                    if (jump_en) begin
                        pend_q <= 1'b1;
                        tgt_q  <= jump_addr;
                    end
                    if (mem.imem_ack) buf_q <= mem.imem_data;
                end
                LOAD: begin
                    pc_q   <= jump_en ? jump_addr : (pend_q ? tgt_q : pc_q + 1'b1);
                    pend_q <= 1'b0;
                    if (buf_q == HALT_WORD) halted_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
